conv1_patch_scheduler: RTL and testbench

Sequencer for the 32-filter 3x3 conv layer-1 MAC array. It walks a stride-1, no-padding window across an IMG_H x IMG_W fp32 image held in an external single-port memory. For each output position it fetches the 9 pixels, presents the packed 288-bit patch to the MAC/ReLU array, and waits the array's fixed latency. It then captures the 1024-bit post-ReLU result and hands it downstream through a valid/ready interface tagged with the output row/column.

---
 rtl/conv1_patch_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_conv1_patch_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_patch_scheduler.sv
// conv1_patch_scheduler: slides a 3x3 stride-1 window over the image,
// feeds each patch to the MAC array and hands its result downstream.
module conv1_patch_scheduler #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int ADDR_W  = 10,
    parameter int MAC_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                img_rd_en,
    output logic [ADDR_W-1:0]   img_rd_addr,
    input  logic [31:0]         img_rd_data,
    output logic [287:0]        patch_flat,
    input  logic [1023:0]       mac_result_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1023:0]       out_data,
    output logic [7:0]          out_row,
    output logic [7:0]          out_col
);

    localparam int WC_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAC_LAT - 1);
    localparam logic [7:0] COL_LAST = 8'(IMG_W - 3);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CAPT,
        S_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [3:0]        k_q, k_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [287:0]      patch_q, patch_d;
    logic [1023:0]     out_data_q, out_data_d;
    logic [7:0]        out_row_q, out_row_d;
    logic [7:0]        out_col_q, out_col_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic [3:0]        slot;
    logic [1:0]        ky;
    logic [1:0]        kx;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        patch_d     = patch_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        slot        = k_q - 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    k_d     = 4'd0;
                end
            end
            S_FETCH: begin
                // data returned this cycle belongs to the previous read
                if (k_q != 4'd0) begin
                    patch_d[{slot, 5'b0} +: 32] = img_rd_data;
                end
                if (k_q == 4'd9) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WC_LAST) begin
                    state_d = S_CAPT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                out_data_d  = mac_result_flat;
                out_row_d   = row_q;
                out_col_d   = col_q;
                out_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    k_d         = 4'd0;
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + 8'd1;
                        state_d = S_FETCH;
                    end else if (row_q < ROW_LAST) begin
                        col_d   = 8'd0;
                        row_d   = row_q + 8'd1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // read strobe and address are registered one step ahead of use
        ky = (k_d >= 4'd6) ? 2'd2 : ((k_d >= 4'd3) ? 2'd1 : 2'd0);
        kx = 2'(k_d - 4'(ky) * 4'd3);
        addr = (ADDR_W'(row_d) + ADDR_W'(ky)) * ADDR_W'(IMG_W)
             + ADDR_W'(col_d) + ADDR_W'(kx);
        rd_en_d   = (state_d == S_FETCH) && (k_d <= 4'd8);
        rd_addr_d = rd_en_d ? addr : rd_addr_q;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            patch_q     <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            patch_q     <= patch_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign img_rd_en   = rd_en_q;
    assign img_rd_addr = rd_addr_q;
    assign patch_flat  = patch_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;

endmodule

// File: tb/tb_conv1_patch_scheduler.sv
// Bench for conv1_patch_scheduler: random-ready scoreboard against a
// position-list model of the window walk, plus directed corner cases.
module tb_conv1_patch_scheduler;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int AW   = 10;
    localparam int LAT  = 2;
    localparam int NPOS = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          img_rd_en;
    logic [AW-1:0] img_rd_addr;
    logic [31:0]   img_rd_data;
    logic [287:0]  patch_flat;
    logic [1023:0] mac_result_flat;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] out_data;
    logic [7:0]    out_row;
    logic [7:0]    out_col;

    conv1_patch_scheduler #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MAC_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .done(done), .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
        .img_rd_data(img_rd_data), .patch_flat(patch_flat),
        .mac_result_flat(mac_result_flat), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    r;
        logic [7:0]    c;
        logic [1023:0] d;
    } exp_t;

    exp_t          out_q[$];
    logic [AW-1:0] addr_q[$];
    exp_t          head;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int exp_left = 0;
    bit expect_done = 0;
    int ready_mode = 0;
    bit rnd_start = 0;
    bit req_start = 0;
    bit chain = 0;
    logic [1023:0] mac_p1, mac_p2;

    // memory holds its own address; reads outside a strobe return junk
    always @(posedge clk)
        img_rd_data <= img_rd_en ? 32'(img_rd_addr) : 32'hDEADBEEF;

    // MAC array: word f = patch slot (f mod 9) xor f, two-stage latency
    always @(posedge clk) begin
        for (int f = 0; f < 32; f++)
            mac_p1[f*32 +: 32] <= patch_flat[(f % 9)*32 +: 32] ^ 32'(f);
        mac_p2 <= mac_p1;
    end
    assign mac_result_flat = mac_p2;

    task automatic chk(input string name, input logic [287:0] act,
                       input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [1023:0] act,
                            input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int f = 0; f < 32; f++)
                if (act[f*32 +: 32] !== exp[f*32 +: 32]) begin
                    $display("FAIL %s word%0d got=%0h want=%0h t=%0t", name,
                             f, act[f*32 +: 32], exp[f*32 +: 32], $time);
                    break;
                end
        end
    endtask

    function automatic void push_pass();
        exp_t e;
        int s;
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c <= W - 3; c++) begin
                for (int j = 0; j < 9; j++)
                    addr_q.push_back(AW'((r + j / 3) * W + c + j % 3));
                e.r = 8'(r);
                e.c = 8'(c);
                for (int f = 0; f < 32; f++) begin
                    s = f % 9;
                    e.d[f*32 +: 32] = 32'((r + s / 3) * W + c + s % 3)
                                    ^ 32'(f);
                end
                out_q.push_back(e);
            end
        exp_left += NPOS;
    endfunction

    // input driver: ready pattern, requested starts, stray starts while busy
    initial begin
        start = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (req_start || (chain && done)) begin
                push_pass();
                start = 1'b1;
                req_start = 0;
                chain = 0;
            end else begin
                start = rnd_start && busy && ($urandom_range(0, 5) == 0);
            end
        end
    end

    // monitor: compares every presented output against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (expect_done) begin
                chk("done_pulse", 288'(done), 288'(1));
                expect_done = 0;
            end else if (done) begin
                chk("spurious_done", 288'(done), 288'(0));
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 288'(busy), 288'(0));
            end
            if (img_rd_en) begin
                if (addr_q.size() == 0)
                    chk("rd_en_extra", 288'(img_rd_en), 288'(0));
                else
                    chk("rd_addr", 288'(img_rd_addr),
                        288'(addr_q.pop_front()));
            end
            if (out_valid) begin
                chk("busy_in_emit", 288'(busy), 288'(1));
                if (out_q.size() == 0) begin
                    chk("valid_extra", 288'(out_valid), 288'(0));
                end else begin
                    head = out_q[0];
                    chk("out_row", 288'(out_row), 288'(head.r));
                    chk("out_col", 288'(out_col), 288'(head.c));
                    chk_data("out_data", out_data, head.d);
                    if (!out_ready) begin
                        chk("rd_en_in_stall", 288'(img_rd_en), 288'(0));
                    end else begin
                        void'(out_q.pop_front());
                        xfer_cnt++;
                        exp_left--;
                        if (exp_left == 0) expect_done = 1;
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 288'(busy), 288'(0));
        chk({tag, "_done"}, 288'(done), 288'(0));
        chk({tag, "_valid"}, 288'(out_valid), 288'(0));
        chk({tag, "_rd_en"}, 288'(img_rd_en), 288'(0));
        chk({tag, "_rd_addr"}, 288'(img_rd_addr), 288'(0));
        chk({tag, "_patch"}, patch_flat, 288'(0));
        chk({tag, "_row"}, 288'(out_row), 288'(0));
        chk({tag, "_col"}, 288'(out_col), 288'(0));
        chk_data({tag, "_data"}, out_data, 1024'(0));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++)
            @(posedge clk);
        @(negedge clk);
        chk("done_count", 288'(done_cnt), 288'(target));
    endtask

    initial begin
        int n;
        int base;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        // pass 1: always ready, stray starts; measure first-valid latency
        rnd_start = 1;
        @(negedge clk);
        req_start = 1;
        @(posedge clk);
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #2;
            if (out_valid) break;
        end
        chk("first_valid_latency", 288'(n), 288'(13));
        wait_done(1);

        // pass 2: hold ready low through the first result, then random
        ready_mode = 2;
        @(negedge clk);
        req_start = 1;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("valid_before_hold", 288'(out_valid), 288'(1));
        repeat (5) @(posedge clk);
        ready_mode = 1;
        chain = 1;
        wait_done(2);

        // pass 3 was started in the done cycle of pass 2
        wait_done(3);

        // pass 4: reset during WAIT of position (1,1)
        rnd_start = 0;
        ready_mode = 0;
        base = xfer_cnt;
        @(negedge clk);
        req_start = 1;
        for (int i = 0; i < 200 && xfer_cnt != base + 4; i++) begin
            @(posedge clk);
            #3;
        end
        chk("xfers_before_reset", 288'(xfer_cnt), 288'(base + 4));
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        out_q.delete();
        addr_q.delete();
        exp_left = 0;
        expect_done = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("done_after_abort", 288'(done_cnt), 288'(3));

        // pass 5: restart from (0,0) with random ready and stray starts
        rnd_start = 1;
        ready_mode = 1;
        @(negedge clk);
        req_start = 1;
        wait_done(4);
        rnd_start = 0;
        repeat (20) @(negedge clk);

        chk("final_done_count", 288'(done_cnt), 288'(4));
        chk("total_xfers", 288'(xfer_cnt), 288'(4 * NPOS + 4));
        chk("addr_q_left", 288'(addr_q.size()), 288'(0));
        chk("out_q_left", 288'(out_q.size()), 288'(0));
        chk("idle_busy", 288'(busy), 288'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
